// File: rtl/psram_ctrl.sv
// psram_ctrl: QSPI PSRAM initiator; each request becomes one CE-framed opcode/address/data burst (PSRAM_CTRL_ERR_EN adds size/alignment rejection).
// Latency: accept to resp_valid is 2*(14+NB)+1 cycles for writes, 2*(14+DUMMY_CYC+NB)+1 for reads; one request in flight.
// Backpressure: req_ready is high only in IDLE; the response is held stable until resp_ready.
module psram_ctrl #(
  parameter logic [7:0] CMD_WRITE = 8'h38,
  parameter logic [7:0] CMD_READ  = 8'hEB,
  parameter int         DUMMY_CYC = 6,
  parameter int         CE_GAP    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_out,
  output logic [3:0]  dio_oe,
  input  logic [3:0]  dio_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_RESP, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  nb_q;
  logic        write_q;
  logic [7:0]  cmd_sh;
  logic [23:0] addr_sh;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        sck_d;
  logic        ce_n_d;
  logic        accept;
  logic        req_bad;
  logic [3:0]  req_nb;
  logic [4:0]  nib_pos;
  logic        data_tail;

`ifdef PSRAM_CTRL_ERR_EN
  assign req_bad = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
  assign req_bad = 1'b0;
`endif

  always_comb begin
    case (req_size)
      2'd0:    req_nb = 4'd2;
      2'd1:    req_nb = 4'd4;
      default: req_nb = 4'd8;
    endcase
  end

  // Nibble k lives in byte k/2, high half first.
  assign nib_pos   = {cnt_q[2:1], ~cnt_q[0], 2'b00};
  assign data_tail = (cnt_q == nb_q);
  assign accept    = req_valid && (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sck_d      = 1'b0;
    dio_oe     = 4'h0;
    dio_out    = 4'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? S_RESP : S_CMD;
      end
      S_CMD: begin
        sck_d   = ~sck;
        dio_oe  = 4'b0001;
        dio_out = {3'b000, cmd_sh[7]};
        if (sck && cnt_q == 4'd7) state_d = S_ADDR;
      end
      S_ADDR: begin
        sck_d   = ~sck;
        dio_oe  = 4'hF;
        dio_out = addr_sh[23:20];
        if (sck && cnt_q == 4'd5) state_d = write_q ? S_WDATA : S_DUMMY;
      end
      S_DUMMY: begin
        sck_d = ~sck;
        if (sck && cnt_q == 4'(DUMMY_CYC - 1)) state_d = S_RDATA;
      end
      S_WDATA: begin
        dio_oe = 4'hF;
        // One trailing low cycle lets sck settle low before ce_n rises.
        if (data_tail) begin
          state_d = S_RESP;
        end else begin
          sck_d   = ~sck;
          dio_out = wdata_q[nib_pos +: 4];
        end
      end
      S_RDATA: begin
        if (data_tail) state_d = S_RESP;
        else           sck_d   = ~sck;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == 4'(CE_GAP - 1)) state_d = S_IDLE;
      end
      default: state_d = S_GAP;
    endcase
    ce_n_d = !(state_d inside {S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA});
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_GAP;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      sck     <= 1'b0;
      ce_n    <= 1'b1;
      nb_q    <= 4'd0;
      write_q <= 1'b0;
      cmd_sh  <= 8'h00;
      addr_sh <= 24'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      sck  <= sck_d;
      ce_n <= ce_n_d;
      if (state_d != state_q)             cnt_q <= 4'd0;
      else if (sck || state_q == S_GAP)   cnt_q <= cnt_q + 4'd1;
      if (accept) begin
        write_q <= req_write;
        cmd_sh  <= req_write ? CMD_WRITE : CMD_READ;
        addr_sh <= req_addr;
        wdata_q <= req_wdata;
        nb_q    <= req_nb;
        rdata_q <= 32'h0;
        err_q   <= req_bad;
      end
      if (state_q == S_CMD && sck)  cmd_sh  <= {cmd_sh[6:0], 1'b0};
      if (state_q == S_ADDR && sck) addr_sh <= {addr_sh[19:0], 4'h0};
      if (state_q == S_RDATA && sck) rdata_q[nib_pos +: 4] <= dio_in;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
